// File: rtl/frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_reader: Wishbone reader that streams one frame buffer as valid/ready
// pixels. Revision: 1.0
// ----------------------------------------------------------------------------
module frame_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  input  logic [DATA_WIDTH-1:0] buf_id,
  input  logic                  start_read,
  output logic                  frame_done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int                  PROD_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BUF_WORDS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   index;
  logic [PROD_W-1:0]       base_prod;
  logic                    unused_prod;

  // Only the low ADDR_WIDTH bits of the product matter: addressing wraps.
  assign base_prod   = PROD_W'(buf_id) * PROD_W'(BUF_WORDS);
  assign unused_prod = ^base_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_read) state_next = READ;
      READ: if (wbm_ack) state_next = OUT;
      OUT:  if (pix_ready) state_next = pix_last ? DONE : READ;
      DONE: if (!start_read) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base      <= '0;
      index     <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_read) begin
            base  <= base_prod[ADDR_WIDTH-1:0];
            index <= '0;
          end
        end
        READ: begin
          if (wbm_ack) begin
            pix_data  <= wbm_readdata;
            pix_valid <= 1'b1;
            pix_last  <= (index == LAST_IDX);
          end
        end
        OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (!pix_last) index <= index + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wbm_cycle     = (state == READ);
  assign wbm_strobe    = (state == READ);
  assign wbm_write     = 1'b0;
  assign wbm_writedata = '0;
  assign wbm_address   = (state == READ) ? (base + index) : '0;
  assign frame_done    = (state == DONE);
  assign busy          = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_reader: scoreboard bench for three frame_reader configurations.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_frame_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start [3];
  logic [31:0] bid   [3];
  logic        rdy   [3];
  logic        mon_en[3];

  wire         cyc  [3];
  wire         stb  [3];
  wire         we   [3];
  wire         ack_w[3];
  wire         done [3];
  wire         busy [3];
  wire         pv   [3];
  wire         pl   [3];
  wire  [31:0] wdat [3];
  wire  [31:0] pd   [3];
  wire  [15:0] adr  [3];

  int          frames[3] = '{0, 0, 0};
  logic [15:0] exp_a[3][$];
  logic [32:0] exp_p[3][$];

  function automatic int aw_of(input int k);
    return (k == 1) ? 4 : 16;
  endfunction

  function automatic int bw_of(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance 0: AW16/BW8, instance 1: AW4/BW8 (wrap), instance 2: AW16/BW1.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int AW = (g == 1) ? 4 : 16;
      localparam int BW = (g == 2) ? 1 : 8;
      logic [AW-1:0] a_l;
      logic          ack_l;
      logic [31:0]   rd_l;
      int            wc;
      int            ws;

      frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BUF_WORDS(BW)) u_dut (
        .clk          (clk),
        .reset        (rst_n),
        .wbm_address  (a_l),
        .wbm_writedata(wdat[g]),
        .wbm_readdata (rd_l),
        .wbm_strobe   (stb[g]),
        .wbm_cycle    (cyc[g]),
        .wbm_write    (we[g]),
        .wbm_ack      (ack_l),
        .buf_id       (bid[g]),
        .start_read   (start[g]),
        .frame_done   (done[g]),
        .busy         (busy[g]),
        .pix_data     (pd[g]),
        .pix_valid    (pv[g]),
        .pix_ready    (rdy[g]),
        .pix_last     (pl[g])
      );

      assign adr[g]   = 16'(a_l);
      assign ack_w[g] = ack_l;

      // Memory slave: mem[a] = a + 0x100, 0..2 random wait states.
      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ack_l <= 1'b0;
          rd_l  <= '0;
          wc    <= 0;
          ws    <= 0;
        end else begin
          ack_l <= 1'b0;
          if (cyc[g] && stb[g] && !ack_l) begin
            if (wc >= ws) begin
              ack_l <= 1'b1;
              rd_l  <= 32'(a_l) + 32'h100;
              wc    <= 0;
              ws    <= $urandom_range(0, 2);
            end else begin
              wc <= wc + 1;
            end
          end
        end
      end
    end
  endgenerate

  logic        p_cyc [3];
  logic        p_ack [3];
  logic        p_pv  [3];
  logic        p_rdy [3];
  logic        p_done[3];
  logic [32:0] p_pd  [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_en[k]) begin
        if (cyc[k] && ack_w[k]) begin
          chk("read expected", exp_a[k].size() != 0, 1);
          if (exp_a[k].size() != 0) chk("wb address", adr[k], exp_a[k].pop_front());
          chk("wb we", we[k], 0);
          chk("wb stb", stb[k], 1);
          chk("wb wdata", wdat[k], 0);
        end
        if (p_cyc[k] && p_ack[k]) chk("cyc drop after ack", cyc[k], 0);
        if (p_pv[k] && !p_rdy[k]) begin
          chk("valid held", pv[k], 1);
          chk("data held", {pl[k], pd[k]}, p_pd[k]);
          chk("no read in stall", cyc[k], 0);
        end
        if (pv[k] && rdy[k]) begin
          chk("pixel expected", exp_p[k].size() != 0, 1);
          if (exp_p[k].size() != 0) chk("pixel", {pl[k], pd[k]}, exp_p[k].pop_front());
        end
      end
      if (done[k] && !p_done[k]) frames[k]++;
      p_cyc[k]  = cyc[k];
      p_ack[k]  = ack_w[k];
      p_pv[k]   = pv[k];
      p_rdy[k]  = rdy[k];
      p_done[k] = done[k];
      p_pd[k]   = {pl[k], pd[k]};
    end
  end

  task automatic frame(input int k, input int id, input int hold,
                       input bit chg, input bit bp, input bit early);
    int bw;
    int mask;
    int a;
    int n;
    int stall;
    int f0;
    logic [31:0] d2;
    bw    = bw_of(k);
    mask  = (1 << aw_of(k)) - 1;
    n     = 0;
    stall = 0;
    f0    = frames[k];
    for (int i = 0; i < bw; i++) begin
      a = (id * bw + i) & mask;
      exp_a[k].push_back(16'(a));
      exp_p[k].push_back({(i == bw - 1), 32'(a) + 32'h100});
    end
    d2 = 32'(((id * bw + 2) & mask) + 'h100);
    bid[k]   = 32'(id);
    start[k] = 1'b1;
    while (!done[k] && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (chg && n == 6) bid[k] = 32'd5;
      if (early && n == 3) start[k] = 1'b0;
      if (bp) begin
        if (pv[k] && pd[k] == d2 && stall < 5) begin
          rdy[k] = 1'b0;
          stall++;
        end else begin
          rdy[k] = 1'b1;
        end
      end
    end
    chk("frame_done reached", done[k], 1);
    chk("all pixels out", exp_p[k].size(), 0);
    chk("all reads done", exp_a[k].size(), 0);
    chk("busy in done", busy[k], 1);
    if (bp) chk("stall cycles", stall, 5);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("done held", done[k], 1);
    end
    start[k] = 1'b0;
    @(posedge clk); #1;
    chk("done fall", done[k], 0);
    chk("idle busy", busy[k], 0);
    chk("one frame", frames[k] - f0, 1);
    rdy[k] = 1'b1;
  endtask

  initial begin
    int n;
    int f0;
    for (int k = 0; k < 3; k++) begin
      start[k]  = 1'b0;
      bid[k]    = '0;
      rdy[k]    = 1'b1;
      mon_en[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset cyc", cyc[k], 0);
      chk("reset stb", stb[k], 0);
      chk("reset addr", adr[k], 0);
      chk("reset valid", pv[k], 0);
      chk("reset last", pl[k], 0);
      chk("reset data", pd[k], 0);
      chk("reset done", done[k], 0);
      chk("reset busy", busy[k], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(0, 0, 0, 1'b0, 1'b0, 1'b0);   // basic frame
    frame(0, 3, 0, 1'b1, 1'b0, 1'b0);   // buf_id changed mid-frame
    frame(0, 1, 0, 1'b0, 1'b1, 1'b0);   // backpressure on word 2

    f0 = frames[0];
    for (int i = 0; i < 5; i++) frame(0, i, (i == 2) ? 3 : 0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle no done", done[0], 0);
      chk("idle not busy", busy[0], 0);
    end
    chk("five frames", frames[0] - f0, 5);

    frame(0, 2, 0, 1'b0, 1'b0, 1'b1);   // start_read dropped mid-frame

    // Asynchronous reset during the word-4 read.
    mon_en[0] = 1'b0;
    bid[0]    = 32'd2;
    start[0]  = 1'b1;
    n = 0;
    while (!(cyc[0] && adr[0] == 16'd20) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached word 4 read", cyc[0] && adr[0] == 16'd20, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async cyc", cyc[0], 0);
    chk("async stb", stb[0], 0);
    chk("async addr", adr[0], 0);
    chk("async valid", pv[0], 0);
    chk("async last", pl[0], 0);
    chk("async data", pd[0], 0);
    chk("async done", done[0], 0);
    chk("async busy", busy[0], 0);
    start[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en[0] = 1'b1;
    frame(0, 2, 0, 1'b0, 1'b0, 1'b0);   // fresh frame from index 0

    frame(1, 3, 0, 1'b0, 1'b0, 1'b0);   // address wrap: 8..15
    frame(2, 7, 0, 1'b0, 1'b0, 1'b0);   // single-word frame

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Wishbone-master read-out stage sitting directly downstream of buf_updater.
- Once a frame buffer has been updated in the shared mem, this block reads that buffer word-by-word and streams the pixels to the LED output driver over a valid/ready interface.
- Uses the same buffer-select/handshake style as buf_updater: buf_id plus a four-phase request/done pair.

Parameters:
ADDR_WIDTH, 16, wishbone address width
DATA_WIDTH, 32, wishbone data width and pixel word width
BUF_WORDS, 64, words per frame buffer (1..2^ADDR_WIDTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wbm_address  out  ADDR_WIDTH  wishbone address
wbm_writedata  out  DATA_WIDTH  wishbone write data, constant 0
wbm_readdata  in  DATA_WIDTH  wishbone read data
wbm_strobe  out  1  wishbone strobe
wbm_cycle  out  1  wishbone cycle
wbm_write  out  1  wishbone write enable, constant 0
wbm_ack  in  1  wishbone acknowledge
buf_id  in  DATA_WIDTH  frame buffer to read, latched at start
start_read  in  1  request, level, held until frame_done
frame_done  out  1  frame fully consumed, four-phase done
busy  out  1  high in any state other than IDLE
pix_data  out  DATA_WIDTH  pixel word
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accepts pixel
pix_last  out  1  qualifies final word of frame

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-low. While reset is low, all outputs are 0, state=IDLE and index=0.
- Reset mid-frame aborts immediately, with no bus cleanup. The slave must tolerate cyc dropping.
- States: IDLE, READ, OUT, DONE.
- IDLE:
  - When start_read=1, latch base=(buf_id*BUF_WORDS) truncated to ADDR_WIDTH, set index=0, and go to READ.
  - Changes to buf_id after the latch are ignored.
- READ:
  - wbm_cycle=wbm_strobe=1, wbm_write=0, wbm_address=base+index (mod 2^ADDR_WIDTH).
  - Registered outputs assert in the first cycle of READ.
  - On wbm_ack=1:
    - capture wbm_readdata into pix_data;
    - set pix_valid=1 and pix_last=(index==BUF_WORDS-1);
    - go to OUT.
  - cyc and stb are low from the next cycle on.
  - Wait states are unbounded.
- OUT:
  - pix_data, pix_valid and pix_last are held stable until pix_ready=1. Data must not change while valid is high and ready is low.
  - On the handshake, pix_valid drops the next cycle.
  - If pix_last was set, go to DONE. Otherwise index+=1 and go to READ.
  - Exactly one wishbone transaction per pixel; no prefetch.
  - Minimum 3 cycles per word: READ (ack), OUT (handshake), then back to READ.
- DONE:
  - frame_done=1.
  - Return to IDLE in the cycle after start_read is seen low.
  - If start_read is already low on entry, frame_done is high for exactly 1 cycle.
  - A new frame cannot start until frame_done has dropped: IDLE is entered with frame_done=0.
- start_read deasserted mid-frame is ignored; the frame completes to DONE.
- wbm_ack outside READ is ignored.
- pix_ready while pix_valid=0 is ignored.
- BUF_WORDS=1: a single read, with pix_last=1 on that word.
- busy=1 in READ, OUT and DONE.

Test Plan:
- Basic frame, BUF_WORDS=8, mem[a]=a+0x100, buf_id=0, pix_ready=1 constant → pix_data sequence 0x100..0x107. pix_last=1 only on 0x107. frame_done rises after the last handshake and falls 1 cycle after start_read drops.
- buf_id=3, BUF_WORDS=8:
  - wbm_address runs 24..31;
  - each transaction has cyc=stb=1 and we=0 until ack, then cyc/stb deasserted ≥1 cycle;
  - buf_id changed to 5 mid-frame → addresses unaffected.
- Backpressure: pix_ready low 5 cycles on word 2 → pix_data and pix_valid stable for those cycles, no wishbone cycle issued, no word lost or duplicated.
- Four-phase handshake, run as for the testbench loop: issue 5 back-to-back requests, each holding start_read until frame_done, then 3 idle cycles → 5 complete frames and no spurious frame_done. With start_read held high in DONE, frame_done stays high.
- Asynchronous reset low during word 4 READ → all outputs 0 immediately without a clk edge. After release, start_read gives a fresh frame starting at index 0.
- Address wrap, ADDR_WIDTH=4, BUF_WORDS=8, buf_id=3 → base=24 mod 16=8, addresses 8..15.
